// File: rtl/jtag_ir_param.sv
// Parametrised JTAG instruction register: status capture, LSB-first shift,
// TLR/reset to IDCODE and a registered one-hot decode that falls back to BYPASS.
module jtag_ir_param #(
    parameter int unsigned         IR_WIDTH  = 5,
    parameter logic [IR_WIDTH-1:0] OP_EXTEST = {IR_WIDTH{1'b0}},
    parameter logic [IR_WIDTH-1:0] OP_SAMPLE = {{(IR_WIDTH-2){1'b0}}, 2'b10},
    parameter logic [IR_WIDTH-1:0] OP_IDCODE = {{(IR_WIDTH-1){1'b0}}, 1'b1},
    parameter logic [IR_WIDTH-1:0] OP_BYPASS = {IR_WIDTH{1'b1}}
) (
    input  logic                TCK,
    input  logic                TRST,
    input  logic                TDI,
    input  logic                Capture_IR,
    input  logic                Shift_IR,
    input  logic                Update_IR,
    input  logic                Test_Logic_Reset,
    input  logic [IR_WIDTH-3:0] Status_in,
    output logic                TDO,
    output logic                TDO_en,
    output logic [IR_WIDTH-1:0] IR_out,
    output logic                Sel_extest,
    output logic                Sel_sample,
    output logic                Sel_idcode,
    output logic                Sel_bypass,
    output logic                Invalid_op
);

    // Decode word layout: {extest, sample, idcode, bypass, invalid}
    localparam logic [4:0] DEC_IDCODE = 5'b00100;
    localparam logic [IR_WIDTH-1:0] SHIFT_RESET = {{(IR_WIDTH-2){1'b0}}, 2'b01};

    // Elaboration-time legality checks
    if (IR_WIDTH < 3) begin : g_bad_width
        $error("jtag_ir_param: IR_WIDTH must be at least 3");
    end
    if (OP_EXTEST == OP_SAMPLE || OP_EXTEST == OP_IDCODE || OP_EXTEST == OP_BYPASS ||
        OP_SAMPLE == OP_IDCODE || OP_SAMPLE == OP_BYPASS || OP_IDCODE == OP_BYPASS)
    begin : g_dup_op
        $error("jtag_ir_param: opcode parameters must be distinct");
    end

    function automatic logic [4:0] decode(input logic [IR_WIDTH-1:0] op);
        logic [4:0] d;
        if (op == OP_EXTEST)      d = 5'b10000;
        else if (op == OP_SAMPLE) d = 5'b01000;
        else if (op == OP_IDCODE) d = 5'b00100;
        else if (op == OP_BYPASS) d = 5'b00010;
        else                      d = 5'b00011; // unknown opcode behaves as BYPASS
        return d;
    endfunction

    logic [IR_WIDTH-1:0] shift_q, shift_d;
    logic [IR_WIDTH-1:0] ir_q, ir_d;
    logic [4:0]          dec_q, dec_d;

    // Next state: only the highest-priority strobe acts
    always_comb begin
        shift_d = shift_q;
        ir_d    = ir_q;
        dec_d   = dec_q;
        if (Test_Logic_Reset) begin
            ir_d  = OP_IDCODE;
            dec_d = DEC_IDCODE;
        end else if (Capture_IR) begin
            shift_d = {Status_in, 2'b01};
        end else if (Shift_IR) begin
            shift_d = {TDI, shift_q[IR_WIDTH-1:1]};
        end else if (Update_IR) begin
            // decode taken from shift_q so selects move on the same edge as IR_out
            ir_d  = shift_q;
            dec_d = decode(shift_q);
        end
    end

    // State registers with asynchronous TRST
    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            shift_q <= SHIFT_RESET;
            ir_q    <= OP_IDCODE;
            dec_q   <= DEC_IDCODE;
        end else begin
            shift_q <= shift_d;
            ir_q    <= ir_d;
            dec_q   <= dec_d;
        end
    end

    // Output mapping
    always_comb begin
        TDO        = shift_q[0];
        TDO_en     = Shift_IR;
        IR_out     = ir_q;
        Sel_extest = dec_q[4];
        Sel_sample = dec_q[3];
        Sel_idcode = dec_q[2];
        Sel_bypass = dec_q[1];
        Invalid_op = dec_q[0];
    end

endmodule
